// File: rtl/fifo19_rr_arb_if.sv
// Handshake bundle for fifo19_rr_arb: four fifo19-style input streams and
// one merged output stream.
//   in_data      four input words, input n at [n*WIDTH +: WIDTH]
//   in_src_rdy   per-input source ready
//   in_dst_rdy   per-input destination ready (driven by the arbiter)
//   out_data     selected word (driven by the arbiter)
//   out_src_rdy  output source ready (driven by the arbiter)
//   out_dst_rdy  downstream ready
// Modports: slave = arbiter side, master = the sources/sink around it.
interface fifo19_rr_arb_if #(
  parameter int WIDTH = 19
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_src_rdy;
  logic [3:0]         in_dst_rdy;
  logic [WIDTH-1:0]   out_data;
  logic               out_src_rdy;
  logic               out_dst_rdy;

  modport slave (
    input  in_data, in_src_rdy, out_dst_rdy,
    output in_dst_rdy, out_data, out_src_rdy
  );

  modport master (
    output in_data, in_src_rdy, out_dst_rdy,
    input  in_dst_rdy, out_data, out_src_rdy
  );
endinterface

// File: rtl/fifo19_rr_arb.sv
// Packet-granular round-robin arbiter merging four fifo19-style streams into
// one. A grant is held from arbitration until the granted input's eof word
// has transferred, so packets never interleave. Each packet costs one idle
// arbitration cycle; the data path itself is combinational.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        synchronous soft clear, same effect as reset
//   bus          fifo19_rr_arb_if.slave handshake bundle
//   grant        index of the currently granted input (held after eof)
//   busy         high while a packet is in progress
//   debug        {18'b0, out_dst_rdy, out_src_rdy, in_dst_rdy, in_src_rdy,
//                 1'b0, busy, grant}
//
// Optional build macro FIFO19_RR_ARB_PRIO0_EN: input 0 gets strict priority
// at arbitration, inputs 1-3 rotate among themselves. Undefined: plain
// four-way round robin.
//
// state  | meaning
// IDLE   | no packet in progress; arbitrate, all outputs 0
// ACTIVE | granted input connected to the output until its eof transfers
module fifo19_rr_arb #(
  parameter int WIDTH   = 19,
  parameter int EOF_BIT = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  fifo19_rr_arb_if.slave     bus,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [31:0]        debug
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       winner;
  logic             win;
  logic [1:0]       cand;
  logic [WIDTH-1:0] sel_word;
  logic             eof_xfer;

  // Search order starts one past the last granted input and wraps.
  always_comb begin
    winner = 2'd0;
    win    = 1'b0;
    cand   = 2'd0;
`ifdef FIFO19_RR_ARB_PRIO0_EN
    if (bus.in_src_rdy[0]) begin
      win    = 1'b1;
      winner = 2'd0;
    end else begin
      // last only ever holds 1..3 here, so rotate within 1..3
      for (int k = 0; k < 3; k++) begin
        cand = 2'((int'(last) + k) % 3 + 1);
        if (!win && bus.in_src_rdy[cand]) begin
          win    = 1'b1;
          winner = cand;
        end
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!win && bus.in_src_rdy[cand]) begin
        win    = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  assign sel_word = bus.in_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    bus.out_data    = '0;
    bus.out_src_rdy = 1'b0;
    bus.in_dst_rdy  = 4'b0;
    if (state == ACTIVE) begin
      bus.out_data          = sel_word;
      bus.out_src_rdy       = bus.in_src_rdy[grant];
      bus.in_dst_rdy[grant] = bus.out_dst_rdy;
    end
  end

  assign eof_xfer = bus.out_src_rdy & bus.out_dst_rdy & bus.out_data[EOF_BIT];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      last  <= 2'd3;
      grant <= 2'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win) begin
            grant <= winner;
            busy  <= 1'b1;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (eof_xfer) begin
`ifdef FIFO19_RR_ARB_PRIO0_EN
            // grants to the priority input do not move the rotation
            if (grant != 2'd0) last <= grant;
`else
            last <= grant;
`endif
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign debug = {18'b0, bus.out_dst_rdy, bus.out_src_rdy, bus.in_dst_rdy,
                  bus.in_src_rdy, 1'b0, busy, grant};

endmodule
